led_fader: RTL and testbench
============================

# led_fader

LED afterglow stage between the MicroBlaze `led` output port and the board LED pins. Each LED turns on at full brightness as soon as the processor drives it high. When the processor drives it low, the LED does not cut off abruptly. It fades out through 15 PWM brightness levels, one level per prescaled step tick, so short firmware blinks stay visible. A per-channel `fading` status is exported for debug and bench checking.

## Interface
- `NUM_LEDS`, 8: number of independent channels.
- `STEP_DIV`, 1024: clock cycles per fade step; legal range ≥1. At the 16 MHz system clock, a full fade lasts about 0.96 ms.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-high; clears all state immediately.
- `led_in` input, `NUM_LEDS` bits: LED pattern from the processor; may change on any cycle.
- `led_out` output, `NUM_LEDS` bits: PWM-modulated LED drive; registered.
- `fading` output, `NUM_LEDS` bits: channel is off at input but still glowing; registered.

## Operation
- **Input stage:** `led_q <= led_in` every cycle, a single register stage. The processor output is synchronous to the same `clk`, so no further synchronisation is needed.
- **Prescaler:**
  - Counter `div` has width `max(1, $clog2(STEP_DIV))`. It counts 0..STEP_DIV-1 and wraps to 0.
  - `tick` = (`div` == STEP_DIV-1), combinational.
  - With STEP_DIV=1, `tick` is asserted every cycle.
- **PWM counter:** `pwm` is 4 bits, counts 0..14 and wraps to 0, giving a period of 15 cycles. It is free-running and independent of `div`.
- **Level registers:** `lvl[i]` is 4 bits, range 0..15. Each cycle, per channel:
  - If `led_q[i]`=1: `lvl[i] <= 15`. Set wins over a simultaneous `tick`.
  - Else if `tick` and `lvl[i]`≠0: `lvl[i] <= lvl[i]-1`. The level saturates at 0 and never wraps to 15.
  - Else: hold.
- **Output:**
  - `led_out[i] <= (pwm < lvl[i])`, registered.
  - Level 15 gives always on; level 0 gives always off; level k gives high for k of every 15 cycles.
- **Status:** `fading[i] <= (!led_q[i] && lvl[i] != 0)`, registered.
- **Channel independence:** channels share only `div`, `tick` and `pwm`. Channels released on the same cycle fade in lockstep.
- **Reset:** while `reset` is high, every register is held at 0: `led_q`, `div`, `pwm`, `lvl`, `led_out`, `fading`.
  - Reset asserted mid-fade clears the channel to dark immediately, with no resumed fade.
  - After deassertion, `div` and `pwm` restart from 0.

## Timing
- **Reset values:** `led_out`=0 and `fading`=0, asynchronously upon `reset` rise.
- **Turn-on latency, 3 edges:**
  - `led_in[i]` rises before edge n.
  - `led_q` updates at edge n.
  - `lvl`=15 at edge n+1.
  - `led_out[i]`=1 from edge n+2 onward, held constant while the input stays high.
- **Turn-off:**
  - `led_q[i]` goes 0 at edge n.
  - `fading[i]`=1 from edge n+1, computed from the new `led_q` and `lvl`=15.
  - The first decrement happens at the first `tick` edge after n.
  - After exactly 15 ticks `lvl`=0. `led_out[i]` and `fading[i]` reach 0 one edge later.
  - Worst-case dark time after release: 15·STEP_DIV+2 cycles.
- **Re-assertion mid-fade:** `led_q`=1 at edge n gives `lvl`=15 at edge n+1, and `fading`=0 and `led_out`=1 at edge n+2.
- **Glitch filtering:** a one-cycle `led_in` pulse still produces the full turn-on followed by a full fade. There is no minimum-pulse filter.
- **Throughput:** a new `led_in` value is accepted every cycle; there is no handshake or backpressure.

## Test plan
Use STEP_DIV=4 for all scenarios; the clock is 16 MHz (62.5 ns period).

1. **Reset:** assert `reset` with `led_in`=8'hFF.
   - Outputs go to 8'h00 without waiting for a clock.
   - After deassertion, `led_out`=8'hFF from the third edge.
2. **Steady on:** `led_in`=8'h01 held for 100 cycles.
   - `led_out`=8'h01 constantly from edge n+2.
   - `fading`=8'h00 throughout.
3. **Fade profile:** after test 2, drive `led_in`=8'h00.
   - `fading`=8'h01 from edge n+1.
   - In each 15-cycle PWM window, the count of high `led_out[0]` cycles steps down 15→0 through the monotonic levels.
   - `led_out[0]` and `fading[0]` are 0 no later than 15·4+2=62 cycles after release; `lvl` never wraps.
4. **Re-assert mid-fade:** release bit 0, wait for `lvl`=7, then drive `led_in`=8'h01.
   - `led_out[0]` is steady high from edge n+2.
   - `fading[0]`=0 from edge n+2.
   - A `tick` on the set cycle has no effect on the level.
5. **Reset mid-fade:** with channel 3 at `lvl`=9, pulse `reset` for 2 cycles.
   - `led_out`=0 and `fading`=0 immediately and stay 0.
   - `pwm` and `div` restart from 0 after deassertion.
6. **Independence:** `led_in`=8'hA5 for 20 cycles, then 8'h00.
   - Bits 0, 2, 5 and 7 fade in lockstep, with identical `led_out` waveforms.
   - Bits 1, 3, 4 and 6 stay 0 on both outputs throughout.

Source files
------------

// File: rtl/led_fader_if.sv
// LED fader bus: processor LED pattern in, PWM drive and fade status out.
`timescale 1ns/1ps
interface led_fader_if #(parameter int NUM_LEDS = 8);
  logic [NUM_LEDS-1:0] led_in;
  logic [NUM_LEDS-1:0] led_out;
  logic [NUM_LEDS-1:0] fading;

  modport master (output led_in, input led_out, input fading);
  modport slave  (input led_in, output led_out, output fading);
endinterface

// File: rtl/led_fader.sv
// LED afterglow: full brightness while driven, then a 15-level PWM fade-out
// stepping once per prescaler tick after the processor releases the LED.
`timescale 1ns/1ps
module led_fader_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic       led_q,
  input  logic       tick,
  input  logic [3:0] pwm,
  output logic       led_out,
  output logic       fading
);
  logic [3:0] lvl;

  // Level: set to full while driven (set beats tick), else decay on tick, saturating at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     lvl <= 4'd0;
    else if (led_q)                lvl <= 4'd15;
    else if (tick && lvl != 4'd0)  lvl <= lvl - 4'd1;
  end

  // Registered PWM compare and fade status from the current level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= 1'b0;
      fading  <= 1'b0;
    end else begin
      led_out <= (pwm < lvl);
      fading  <= !led_q && (lvl != 4'd0);
    end
  end
endmodule

module led_fader #(
  parameter int NUM_LEDS = 8,
  parameter int STEP_DIV = 1024
) (
  input  logic         clk,
  input  logic         reset,
  led_fader_if.slave   bus
);
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [NUM_LEDS-1:0] led_q;
  logic [DIV_W-1:0]    div;
  logic [3:0]          pwm;
  logic                tick;
  logic [NUM_LEDS-1:0] led_out_w;
  logic [NUM_LEDS-1:0] fading_w;

  // Same-clock source, so one register stage is enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) led_q <= '0;
    else       led_q <= bus.led_in;
  end

  assign tick = (div == DIV_W'(STEP_DIV - 1));

  // Fade-step prescaler, wraps at STEP_DIV-1 (stays 0 when STEP_DIV is 1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div <= '0;
    else if (tick) div <= '0;
    else           div <= div + 1'b1;
  end

  // Free-running 15-cycle PWM period so level 15 is fully on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              pwm <= 4'd0;
    else if (pwm == 4'd14)  pwm <= 4'd0;
    else                    pwm <= pwm + 4'd1;
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    led_fader_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .led_q   (led_q[i]),
      .tick    (tick),
      .pwm     (pwm),
      .led_out (led_out_w[i]),
      .fading  (fading_w[i])
    );
  end

  assign bus.led_out = led_out_w;
  assign bus.fading  = fading_w;
endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with STEP_DIV=4: cycle model feeding a scoreboard queue,
// a table of steady-state vectors, and hand sequences for fade corner cases.
`timescale 1ns/1ps
module tb_led_fader;
  logic clk;
  logic reset;

  led_fader_if #(.NUM_LEDS(8)) bus ();

  led_fader #(.NUM_LEDS(8), .STEP_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #31.25 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] fad;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] led_in;
    int         cycles;
    logic [7:0] exp_out;
    logic [7:0] exp_fad;
  } vec_t;
  vec_t vecs[5];

  // Reference state, advanced once per clock edge.
  logic [7:0] m_led_q, m_out, m_fad;
  logic [1:0] m_div;
  logic [3:0] m_pwm;
  logic [3:0] m_lvl [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    m_led_q = '0; m_out = '0; m_fad = '0; m_div = '0; m_pwm = '0;
    for (int i = 0; i < 8; i++) m_lvl[i] = '0;
  endtask

  task automatic model_next(input logic [7:0] in);
    logic       t;
    logic [3:0] nl [8];
    logic [7:0] no, nf;
    if (reset) begin
      model_reset();
      return;
    end
    t = (m_div == 2'd3);
    for (int i = 0; i < 8; i++) begin
      no[i] = (m_pwm < m_lvl[i]);
      nf[i] = !m_led_q[i] && (m_lvl[i] != 0);
      if (m_led_q[i])            nl[i] = 4'd15;
      else if (t && m_lvl[i] != 0) nl[i] = m_lvl[i] - 4'd1;
      else                       nl[i] = m_lvl[i];
    end
    for (int i = 0; i < 8; i++) m_lvl[i] = nl[i];
    m_out   = no;
    m_fad   = nf;
    m_led_q = in;
    m_div   = m_div + 2'd1;
    m_pwm   = (m_pwm == 4'd14) ? 4'd0 : m_pwm + 4'd1;
  endtask

  // Drive at negedge, push expectation, pop and compare at the next negedge.
  task automatic step(input logic [7:0] in);
    exp_t e;
    bus.led_in = in;
    model_next(in);
    sb.push_back({m_out, m_fad});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("sb_led_out", bus.led_out, e.out);
    check("sb_fading", bus.fading, e.fad);
  endtask

  initial begin
    int hist[80];
    int win[6];
    int last_lit;
    int k;

    vecs[0] = '{8'hFF, 20,  8'hFF, 8'h00};
    vecs[1] = '{8'h00, 80,  8'h00, 8'h00};
    vecs[2] = '{8'hA5, 20,  8'hA5, 8'h00};
    vecs[3] = '{8'h00, 80,  8'h00, 8'h00};
    vecs[4] = '{8'h01, 100, 8'h01, 8'h00};

    reset = 1'b1;
    bus.led_in = 8'hFF;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_out", bus.led_out, 8'h00);
    check("reset_fad", bus.fading, 8'h00);
    reset = 1'b0;

    // Turn-on latency after reset release: on at the third edge.
    step(8'hFF); check("lat_e1", bus.led_out, 8'h00);
    step(8'hFF); check("lat_e2", bus.led_out, 8'h00);
    step(8'hFF); check("lat_e3", bus.led_out, 8'hFF);
    for (int c = 0; c < 10; c++) step(8'hFF);

    // Asynchronous reset: outputs clear without a clock edge.
    #5 reset = 1'b1;
    #1;
    check("async_rst_out", bus.led_out, 8'h00);
    check("async_rst_fad", bus.fading, 8'h00);
    model_reset();
    @(negedge clk);
    step(8'hFF);
    step(8'hFF);
    reset = 1'b0;

    // Steady-state vector table.
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < vecs[v].cycles; c++) begin
        step(vecs[v].led_in);
        if ((vecs[v].led_in != 0 && c >= 2) || c == vecs[v].cycles - 1) begin
          check("vec_out", bus.led_out, vecs[v].exp_out);
          check("vec_fad", bus.fading, vecs[v].exp_fad);
        end
      end
    end

    // Fade profile of channel 0 following the steady-on vector.
    last_lit = 0;
    for (int c = 0; c < 80; c++) begin
      step(8'h00);
      if (c == 1) check("fade_start_fad", bus.fading, 8'h01);
      hist[c] = int'(bus.led_out[0]);
      if (bus.led_out[0] || bus.fading[0]) last_lit = c + 1;
    end
    for (int w = 0; w < 4; w++) begin
      win[w] = 0;
      for (int c = 0; c < 15; c++) win[w] += hist[w*15 + c];
    end
    win[4] = 0;
    for (int c = 62; c < 77; c++) win[4] += hist[c];
    check("win0_full", 8'(win[0] >= 10), 8'h01);
    for (int w = 0; w < 3; w++) check("win_monotonic", 8'(win[w+1] <= win[w]), 8'h01);
    check("win_dark", 8'(win[4]), 8'h00);
    check("dark_by_62", 8'(last_lit <= 62), 8'h01);

    // Re-assert mid-fade at level 7.
    for (int c = 0; c < 3; c++) step(8'h01);
    k = 0;
    while (m_lvl[0] != 4'd7 && k < 200) begin
      step(8'h00);
      k++;
    end
    if (m_lvl[0] != 4'd7) timeout("wait_lvl7");
    step(8'h01);
    step(8'h01);
    for (int c = 0; c < 30; c++) begin
      step(8'h01);
      check("reassert_out0", {7'd0, bus.led_out[0]}, 8'h01);
      check("reassert_fad0", {7'd0, bus.fading[0]}, 8'h00);
    end

    // Reset mid-fade with channel 3 at level 9.
    for (int c = 0; c < 3; c++) step(8'h08);
    k = 0;
    while (m_lvl[3] != 4'd9 && k < 200) begin
      step(8'h00);
      k++;
    end
    if (m_lvl[3] != 4'd9) timeout("wait_lvl9");
    check("pre_rst_fad", bus.fading & 8'h08, 8'h08);
    #5 reset = 1'b1;
    #1;
    check("midfade_rst_out", bus.led_out, 8'h00);
    check("midfade_rst_fad", bus.fading, 8'h00);
    model_reset();
    @(negedge clk);
    step(8'h00);
    step(8'h00);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(8'h00);
      check("post_rst_dark", bus.led_out | bus.fading, 8'h00);
    end
    // Restarted pwm/div are tracked by the scoreboard through a fresh fade.
    for (int c = 0; c < 5; c++) step(8'h08);
    for (int c = 0; c < 70; c++) step(8'h00);

    // Independence: A5 channels fade in lockstep, the others stay dark.
    for (int c = 0; c < 90; c++) begin
      step(c < 20 ? 8'hA5 : 8'h00);
      check("lockstep_out", bus.led_out & 8'hA5, bus.led_out[0] ? 8'hA5 : 8'h00);
      check("idle_out", bus.led_out & 8'h5A, 8'h00);
      check("idle_fad", bus.fading & 8'h5A, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
